// File: rtl/rs_syndrome_seq.sv
// RS(15,13) syndrome sequencer over GF(16), field polynomial x^4+x+1.
// Symbols arrive highest degree first. S1 = r(alpha) and S2 = r(alpha^2)
// are built up by Horner steps. The finished pair is held for the error
// locator behind a valid/ready handshake. Framing faults are counted in a
// saturating counter.
module rs_syndrome_seq #(
    parameter int N_SYM = 15,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [3:0]       sym,
    input  logic             sym_valid,
    input  logic             sym_first,
    output logic             sym_ready,
    output logic [3:0]       synd1,
    output logic [3:0]       synd2,
    output logic             synd_err,
    output logic             synd_valid,
    input  logic             synd_ready,
    output logic [CNT_W-1:0] resync_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Multiply by alpha. Reducing with alpha^4 = alpha + 1 folds bit 3 into bits 0 and 1.
    function automatic logic [3:0] mul_a(input logic [3:0] x);
        return {x[2], x[1], x[0] ^ x[3], x[3]};
    endfunction

    // Multiply by alpha^2. This is two alpha steps chained together.
    function automatic logic [3:0] mul_a2(input logic [3:0] x);
        return mul_a(mul_a(x));
    endfunction

    state_t           r_state;
    logic [3:0]       r_s1;
    logic [3:0]       r_s2;
    logic [4:0]       r_cnt;
    logic             r_sym_ready;
    logic             r_synd_valid;
    logic             r_synd_err;
    logic [3:0]       r_synd1;
    logic [3:0]       r_synd2;
    logic [CNT_W-1:0] r_resync;

    logic             w_accept;
    logic [3:0]       w_s1_nxt;
    logic [3:0]       w_s2_nxt;
    logic [4:0]       w_cnt_nxt;
    logic             w_last;
    logic             w_resync_sat;

    // One Horner step per accepted symbol: S <- S*alpha^k + r_i.
    assign w_accept     = sym_valid & r_sym_ready;
    assign w_s1_nxt     = mul_a(r_s1) ^ sym;
    assign w_s2_nxt     = mul_a2(r_s2) ^ sym;
    assign w_cnt_nxt    = r_cnt + 5'd1;
    assign w_last       = (w_cnt_nxt == 5'(N_SYM));
    assign w_resync_sat = &r_resync;

    // Frame sequencer. It updates the accumulators, the result registers and the fault counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_s1         <= 4'd0;
            r_s2         <= 4'd0;
            r_cnt        <= 5'd0;
            r_sym_ready  <= 1'b0;
            r_synd_valid <= 1'b0;
            r_synd_err   <= 1'b0;
            r_synd1      <= 4'd0;
            r_synd2      <= 4'd0;
            r_resync     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // ready rises on the first edge after reset and stays high in IDLE
                    r_sym_ready <= 1'b1;
                    if (w_accept) begin
                        if (sym_first) begin
                            r_s1    <= sym;
                            r_s2    <= sym;
                            r_cnt   <= 5'd1;
                            r_state <= ST_ACC;
                        end else if (!w_resync_sat) begin
                            // a stray symbol outside a frame is dropped and counted
                            r_resync <= r_resync + CNT_W'(1);
                        end
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        if (sym_first) begin
                            // premature restart: drop the partial frame and begin again
                            if (!w_resync_sat)
                                r_resync <= r_resync + CNT_W'(1);
                            r_s1  <= sym;
                            r_s2  <= sym;
                            r_cnt <= 5'd1;
                        end else begin
                            r_s1  <= w_s1_nxt;
                            r_s2  <= w_s2_nxt;
                            r_cnt <= w_cnt_nxt;
                            if (w_last) begin
                                // the result registers only change here
                                r_synd1      <= w_s1_nxt;
                                r_synd2      <= w_s2_nxt;
                                r_synd_err   <= (w_s1_nxt != 4'd0) || (w_s2_nxt != 4'd0);
                                r_synd_valid <= 1'b1;
                                r_sym_ready  <= 1'b0;
                                r_state      <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (synd_ready) begin
                        r_synd_valid <= 1'b0;
                        r_sym_ready  <= 1'b1;
                        r_cnt        <= 5'd0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_sym_ready  <= 1'b0;
                    r_synd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sym_ready  = r_sym_ready;
    assign synd_valid = r_synd_valid;
    assign synd_err   = r_synd_err;
    assign synd1      = r_synd1;
    assign synd2      = r_synd2;
    assign resync_cnt = r_resync;

endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Directed bench for rs_syndrome_seq (N_SYM=15, CNT_W=8). Every expected
// syndrome was worked out by hand in GF(16) with the polynomial x^4+x+1.
module tb_rs_syndrome_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] sym;
    logic       sym_valid;
    logic       sym_first;
    logic       sym_ready;
    logic [3:0] synd1;
    logic [3:0] synd2;
    logic       synd_err;
    logic       synd_valid;
    logic       synd_ready;
    logic [7:0] resync_cnt;

    int errors = 0;
    int checks = 0;

    rs_syndrome_seq #(.N_SYM(15), .CNT_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sym        (sym),
        .sym_valid  (sym_valid),
        .sym_first  (sym_first),
        .sym_ready  (sym_ready),
        .synd1      (synd1),
        .synd2      (synd2),
        .synd_err   (synd_err),
        .synd_valid (synd_valid),
        .synd_ready (synd_ready),
        .resync_cnt (resync_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one symbol and wait for it to be accepted, giving up after a cycle budget.
    task automatic send(input logic [3:0] s, input logic f);
        int n;
        n = 0;
        sym       = s;
        sym_first = f;
        sym_valid = 1'b1;
        while (!sym_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("send_timeout", {31'd0, sym_ready}, 32'd1);
        tick();
        sym_valid = 1'b0;
        sym_first = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        sym        = 4'd0;
        sym_valid  = 1'b0;
        sym_first  = 1'b0;
        synd_ready = 1'b1;

        // reset values
        #12;
        chk("rst_sym_ready", {31'd0, sym_ready}, 32'd0);
        chk("rst_synd_valid", {31'd0, synd_valid}, 32'd0);
        chk("rst_synd_err", {31'd0, synd_err}, 32'd0);
        chk("rst_synd1", {28'd0, synd1}, 32'd0);
        chk("rst_synd2", {28'd0, synd2}, 32'd0);
        chk("rst_resync", {24'd0, resync_cnt}, 32'd0);
        tick();
        rstn = 1'b1;
        chk("rel_sym_ready_lo", {31'd0, sym_ready}, 32'd0);
        tick();
        chk("rel_sym_ready_hi", {31'd0, sym_ready}, 32'd1);

        // an all-zero codeword sent back to back
        for (int i = 0; i < 15; i++) send(4'h0, i == 0);
        chk("zero_valid", {31'd0, synd_valid}, 32'd1);
        chk("zero_sym_ready", {31'd0, sym_ready}, 32'd0);
        chk("zero_s1", {28'd0, synd1}, 32'd0);
        chk("zero_s2", {28'd0, synd2}, 32'd0);
        chk("zero_err", {31'd0, synd_err}, 32'd0);
        tick();
        chk("zero_valid_drop", {31'd0, synd_valid}, 32'd0);
        chk("zero_ready_back", {31'd0, sym_ready}, 32'd1);

        // 1 at the highest degree: S1 = a^14 = 9, S2 = a^28 = a^13 = D
        send(4'h1, 1'b1);
        for (int i = 0; i < 14; i++) send(4'h0, 1'b0);
        chk("hi_valid", {31'd0, synd_valid}, 32'd1);
        chk("hi_s1", {28'd0, synd1}, 32'h9);
        chk("hi_s2", {28'd0, synd2}, 32'hD);
        chk("hi_err", {31'd0, synd_err}, 32'd1);
        tick();

        // 1 at degree 0, with an idle gap partway through: S1 = S2 = 1
        send(4'h0, 1'b1);
        for (int i = 0; i < 6; i++) send(4'h0, 1'b0);
        tick(); tick(); tick();
        chk("gap_no_valid", {31'd0, synd_valid}, 32'd0);
        for (int i = 0; i < 7; i++) send(4'h0, 1'b0);
        send(4'h1, 1'b0);
        chk("lo_valid", {31'd0, synd_valid}, 32'd1);
        chk("lo_s1", {28'd0, synd1}, 32'h1);
        chk("lo_s2", {28'd0, synd2}, 32'h1);
        tick();

        // all ones: both sums run over every nonzero element, so both are 0
        for (int i = 0; i < 15; i++) send(4'h1, i == 0);
        chk("ones_s1", {28'd0, synd1}, 32'h0);
        chk("ones_s2", {28'd0, synd2}, 32'h0);
        chk("ones_err", {31'd0, synd_err}, 32'd0);
        tick();

        // 1,1,0...: S1 = a^14+a^13 = 4, S2 = a^13+a^11 = 3. The consumer stalls 5 cycles.
        synd_ready = 1'b0;
        send(4'h1, 1'b1);
        send(4'h1, 1'b0);
        for (int i = 0; i < 13; i++) send(4'h0, 1'b0);
        chk("stall_valid0", {31'd0, synd_valid}, 32'd1);
        chk("stall_s1_0", {28'd0, synd1}, 32'h4);
        chk("stall_s2_0", {28'd0, synd2}, 32'h3);
        for (int i = 0; i < 5; i++) begin
            sym       = 4'hA;
            sym_valid = 1'b1;
            sym_first = i[0];
            tick();
            chk("stall_sym_ready", {31'd0, sym_ready}, 32'd0);
            chk("stall_valid", {31'd0, synd_valid}, 32'd1);
            chk("stall_s1", {28'd0, synd1}, 32'h4);
            chk("stall_s2", {28'd0, synd2}, 32'h3);
            chk("stall_resync", {24'd0, resync_cnt}, 32'd0);
        end
        sym_valid  = 1'b0;
        sym_first  = 1'b0;
        synd_ready = 1'b1;
        tick();
        chk("stall_release", {31'd0, synd_valid}, 32'd0);

        // framing faults: three stray symbols while IDLE
        for (int i = 0; i < 3; i++) send(4'h7, 1'b0);
        chk("idle_faults", {24'd0, resync_cnt}, 32'd3);
        chk("idle_no_valid", {31'd0, synd_valid}, 32'd0);
        // premature restart after 7 symbols. The F symbols of the old frame must not leak.
        send(4'hF, 1'b1);
        for (int i = 0; i < 6; i++) send(4'hF, 1'b0);
        send(4'h1, 1'b1);
        chk("restart_fault", {24'd0, resync_cnt}, 32'd4);
        for (int i = 0; i < 13; i++) send(4'h0, 1'b0);
        chk("restart_no_valid", {31'd0, synd_valid}, 32'd0);
        send(4'h0, 1'b0);
        chk("restart_valid", {31'd0, synd_valid}, 32'd1);
        chk("restart_s1", {28'd0, synd1}, 32'h9);
        chk("restart_s2", {28'd0, synd2}, 32'hD);
        tick();

        // asynchronous reset in the middle of a frame
        send(4'h1, 1'b1);
        for (int i = 0; i < 9; i++) send(4'h5, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_s1", {28'd0, synd1}, 32'h0);
        chk("arst_s2", {28'd0, synd2}, 32'h0);
        chk("arst_resync", {24'd0, resync_cnt}, 32'd0);
        chk("arst_sym_ready", {31'd0, sym_ready}, 32'd0);
        chk("arst_valid", {31'd0, synd_valid}, 32'd0);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 15; i++) send(4'h0, i == 0);
        chk("post_rst_valid", {31'd0, synd_valid}, 32'd1);
        chk("post_rst_s1", {28'd0, synd1}, 32'h0);
        chk("post_rst_s2", {28'd0, synd2}, 32'h0);
        tick();

        // the fault counter saturates at 0xFF
        for (int i = 0; i < 254; i++) send(4'h3, 1'b0);
        chk("sat_fe", {24'd0, resync_cnt}, 32'hFE);
        send(4'h3, 1'b0);
        chk("sat_ff", {24'd0, resync_cnt}, 32'hFF);
        for (int i = 0; i < 5; i++) send(4'h3, 1'b0);
        chk("sat_hold", {24'd0, resync_cnt}, 32'hFF);
        chk("sat_no_valid", {31'd0, synd_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_seq.md
Name: rs_syndrome_seq

Overview:
- Sequential syndrome calculator for the lpGBT-FE RS(15,13) decoder over GF(16), field polynomial x^4+x+1.
- Accepts one 4-bit received symbol per handshake, highest-degree symbol first.
- Evaluates S1 = r(alpha) and S2 = r(alpha^2) by Horner iteration on internal multiply-by-alpha and multiply-by-alpha^2 datapaths.
- Presents both syndromes with a valid/ready handshake to the downstream error locator.
- Sequences frames, detects framing faults and back-pressures the symbol source while a result is pending.

Parameters:
- N_SYM, 15, symbols per codeword. Legal range 3..15; smaller values give a shortened code with implicit leading zeros.
- CNT_W, 8, width of the saturating resync counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- sym  input  4  received symbol, bit 0 = coefficient of alpha^0.
- sym_valid  input  1  sym is valid this cycle.
- sym_first  input  1  qualifies sym as the first (highest-degree) symbol of a codeword.
- sym_ready  output  1  block accepts a symbol this cycle.
- synd1  output  4  S1 = r(alpha).
- synd2  output  4  S2 = r(alpha^2).
- synd_err  output  1  (synd1 != 0) or (synd2 != 0); valid only with synd_valid.
- synd_valid  output  1  syndromes are valid.
- synd_ready  input  1  consumer accepts the syndromes.
- resync_cnt  output  CNT_W  saturating count of framing faults.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, S1=S2=0, symbol counter=0, sym_ready=0, synd_valid=0, synd_err=0, synd1=synd2=0, resync_cnt=0.
  - sym_ready goes to 1 on the first clock edge after rstn is deasserted.
- Accept: a symbol is accepted when sym_valid and sym_ready are both 1 on a rising edge.
- GF arithmetic over x^4+x+1:
  - mul_a(x) = {x2, x1, x0^x3, x3}.
  - mul_a2(x) = mul_a(mul_a(x)).
  - Addition is XOR.
- States:
  - IDLE: sym_ready=1.
    - Accept with sym_first=1: S1<=sym, S2<=sym, cnt<=1, go to ACC.
    - Accept with sym_first=0: symbol discarded, resync_cnt+1 (saturating), stay in IDLE.
  - ACC: sym_ready=1.
    - Accept with sym_first=0: S1<=mul_a(S1)^sym, S2<=mul_a2(S2)^sym, cnt<=cnt+1.
    - Accept with sym_first=1 (premature restart): resync_cnt+1; S1<=sym, S2<=sym, cnt<=1; stay in ACC. The partial frame is dropped and no result is emitted.
    - When the accepted symbol makes cnt reach N_SYM, go to DONE.
  - DONE: sym_ready=0, synd_valid=1; synd1/synd2/synd_err held stable.
    - When synd_ready=1: go to IDLE on that edge; synd_valid=0 in the next cycle.
- Latency: last symbol accepted at edge t gives synd_valid=1 in the cycle after t.
  - Minimum frame period is N_SYM+1 cycles when synd_ready is tied high.
- Gaps: sym_valid=0 in IDLE or ACC holds all state.
- synd1/synd2 are registered and only update on entry to DONE; they hold the last result otherwise.
- resync_cnt saturates at 2^CNT_W-1 and is cleared only by reset.
- Reset asserted mid-frame or in DONE: immediate return to the reset values; a partial result is never presented.

Test Plan:
- All-zero codeword, N_SYM=15, back-to-back, synd_ready=1 -> synd_valid 1 cycle after the 15th accept; synd1=0, synd2=0, synd_err=0; sym_ready low for exactly 1 cycle.
- Symbol 0x1 as first symbol, then 14 zeros -> synd1=0x9 (alpha^14), synd2=0xD (alpha^13), synd_err=1.
- 14 zeros then 0x1 as last symbol -> synd1=0x1, synd2=0x1.
- synd_ready held low 5 cycles in DONE -> sym_ready=0 and syndromes stable throughout; sym_valid pulses are ignored and resync_cnt is unchanged.
- Framing faults:
  - 3 symbols with sym_first=0 in IDLE -> resync_cnt=3, no synd_valid.
  - sym_first=1 after 7 symbols in ACC -> resync_cnt=4, and the following 14 symbols complete a frame with syndromes of the new frame only.
- rstn pulsed low after 10 symbols; then a full all-zero frame -> all outputs return to 0 asynchronously; next result has synd1=synd2=0; 255 faults with CNT_W=8 -> resync_cnt stays 0xFF.
